// File: rtl/wb_pkg.sv
// Shared Wishbone constants, responder state encoding and window decode helper.
// Used by wishbone_slave_regfile and intended for future bus targets.
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 32;
    localparam int WB_SEL_W  = 4;

    typedef enum logic [1:0] {
        WBS_IDLE,
        WBS_WAIT,
        WBS_RESP
    } wbs_state_t;

    // Window is DEPTH words starting at base; base is aligned to the window size.
    function automatic logic wb_window_hit(
        input logic [WB_ADDR_W-1:0] adr,
        input logic [WB_ADDR_W-1:0] base,
        input int                   depth
    );
        logic [WB_ADDR_W-1:0] span_mask;
        span_mask = WB_ADDR_W'(depth * 4) - WB_ADDR_W'(1);
        return (adr & ~span_mask) == base;
    endfunction

endpackage

// File: rtl/wb_regfile_mem.sv
// DEPTH x 32-bit register storage with per-byte-lane write enables and
// combinational read; every word resets to RESET_VALUE.
module wb_regfile_mem
    import wb_pkg::*;
#(
    parameter int                     DEPTH       = 16,
    parameter logic [WB_DATA_W-1:0]   RESET_VALUE = '0,
    localparam int                    IDX_W       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [WB_SEL_W-1:0]   wr_sel,
    input  logic [WB_DATA_W-1:0]  wr_dat,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [WB_DATA_W-1:0]  rd_dat
);

    logic [WB_DATA_W-1:0] word_q [DEPTH];

    // Each word owns its storage so only one process ever drives it.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [WB_DATA_W-1:0] word_reg;
            logic                 word_sel;

            assign word_sel = wr_en && (wr_idx == IDX_W'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_reg <= RESET_VALUE;
                end else if (word_sel) begin
                    for (int lane = 0; lane < WB_SEL_W; lane++) begin
                        if (wr_sel[lane]) begin
                            word_reg[8*lane +: 8] <= wr_dat[8*lane +: 8];
                        end
                    end
                end
            end

            assign word_q[gi] = word_reg;
        end
    endgenerate

    assign rd_dat = word_q[rd_idx];

endmodule

// File: rtl/wishbone_slave_regfile.sv
// Wishbone classic single-access responder over a word-addressed register file,
// with programmable wait states. Define WB_SLAVE_ERR_EN to terminate misses with wb_err_o.
module wishbone_slave_regfile
    import wb_pkg::*;
#(
    parameter int                    DEPTH       = 16,
    parameter logic [WB_ADDR_W-1:0]  BASE_ADDR   = 32'h0000_0000,
    parameter int                    WAIT_CYCLES = 1,
    parameter logic [WB_DATA_W-1:0]  RESET_VALUE = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [WB_ADDR_W-1:0]  wb_adr_i,
    input  logic [WB_DATA_W-1:0]  wb_dat_i,
    input  logic [WB_SEL_W-1:0]   wb_sel_i,
    output logic [WB_DATA_W-1:0]  wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    wbs_state_t             state_reg;
    logic [3:0]             wait_cnt_reg;
    logic                   we_reg;
    logic [WB_ADDR_W-1:0]   adr_reg;
    logic [WB_DATA_W-1:0]   dat_reg;
    logic [WB_SEL_W-1:0]    sel_reg;
    logic                   ack_reg;
    logic                   err_reg;
    logic [WB_DATA_W-1:0]   dat_o_reg;

    logic                   req;
    logic                   addr_hit;
    logic [IDX_W-1:0]       reg_idx;
    logic                   mem_wr_en;
    logic [WB_DATA_W-1:0]   mem_rd_dat;

    assign req      = wb_cyc_i & wb_stb_i;
    assign addr_hit = wb_window_hit(adr_reg, BASE_ADDR, DEPTH);
    assign reg_idx  = adr_reg[IDX_W+1:2];

    // The write lands on the same edge that raises wb_ack_o; an abort or reset
    // never reaches RESP, so a partial write cannot happen.
    assign mem_wr_en = (state_reg == WBS_RESP) && we_reg && addr_hit;

    wb_regfile_mem #(
        .DEPTH       (DEPTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (mem_wr_en),
        .wr_idx (reg_idx),
        .wr_sel (sel_reg),
        .wr_dat (dat_reg),
        .rd_idx (reg_idx),
        .rd_dat (mem_rd_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= WBS_IDLE;
            wait_cnt_reg <= 4'd0;
            we_reg       <= 1'b0;
            adr_reg      <= '0;
            dat_reg      <= '0;
            sel_reg      <= '0;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            dat_o_reg    <= '0;
        end else begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
            case (state_reg)
                WBS_IDLE: begin
                    if (req) begin
                        we_reg  <= wb_we_i;
                        adr_reg <= wb_adr_i;
                        dat_reg <= wb_dat_i;
                        sel_reg <= wb_sel_i;
                        if (WAIT_CYCLES == 0) begin
                            state_reg <= WBS_RESP;
                        end else begin
                            state_reg    <= WBS_WAIT;
                            wait_cnt_reg <= WAIT_LOAD;
                        end
                    end
                end
                WBS_WAIT: begin
                    if (!wb_cyc_i) begin
                        state_reg    <= WBS_IDLE;
                        wait_cnt_reg <= 4'd0;
                    end else if (wait_cnt_reg == 4'd0) begin
                        state_reg <= WBS_RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end
                WBS_RESP: begin
                    state_reg <= WBS_IDLE;
`ifdef WB_SLAVE_ERR_EN
                    if (addr_hit) begin
                        ack_reg <= 1'b1;
                        if (!we_reg) begin
                            dat_o_reg <= mem_rd_dat;
                        end
                    end else begin
                        err_reg <= 1'b1;
                    end
`else
                    ack_reg <= 1'b1;
                    if (!we_reg) begin
                        dat_o_reg <= addr_hit ? mem_rd_dat : '0;
                    end
`endif
                end
                default: begin
                    state_reg <= WBS_IDLE;
                end
            endcase
        end
    end

    assign wb_dat_o = dat_o_reg;
    assign wb_ack_o = ack_reg;
    assign wb_err_o = err_reg;

endmodule

// File: tb/tb_wishbone_slave_regfile.sv
// Directed bench for wishbone_slave_regfile: three instances with 0, 1 and 3
// wait cycles, a vector table for single transfers and hand-written corner sequences.
module tb_wishbone_slave_regfile;

    localparam logic [31:0] RV = 32'h5A5A_0000;
`ifdef WB_SLAVE_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc  [3];
    logic        stb  [3];
    logic        we   [3];
    logic [31:0] adr  [3];
    logic [31:0] wdat [3];
    logic [3:0]  sel  [3];
    logic [31:0] rdat [3];
    logic        ack  [3];
    logic        err  [3];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Instance 0: no wait states, 1: one wait state, 2: three wait states.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            wishbone_slave_regfile #(
                .DEPTH       (16),
                .BASE_ADDR   (32'h0000_0000),
                .WAIT_CYCLES ((gi == 0) ? 0 : (gi == 1) ? 1 : 3),
                .RESET_VALUE (RV)
            ) u_dut (
                .clk      (clk),
                .rst_n    (rst_n),
                .wb_cyc_i (cyc[gi]),
                .wb_stb_i (stb[gi]),
                .wb_we_i  (we[gi]),
                .wb_adr_i (adr[gi]),
                .wb_dat_i (wdat[gi]),
                .wb_sel_i (sel[gi]),
                .wb_dat_o (rdat[gi]),
                .wb_ack_o (ack[gi]),
                .wb_err_o (err[gi])
            );
        end
    endgenerate

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_dat;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One classic transfer; cyc/stb held until a termination or the cycle budget runs out.
    task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic ak,
                        output logic er, output int lat);
        @(negedge clk);
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; wdat[k] = d; sel[k] = s;
        @(posedge clk);
        lat = 0; ak = 1'b0; er = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ack[k] || err[k]) break;
        end
        ak = ack[k]; er = err[k]; rd = rdat[k];
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
    endtask

    task automatic run(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [31:0] exp_dat, input logic exp_err,
                       input string tag);
        logic [31:0] rd;
        logic ak, er;
        int lat;
        int exp_lat;
        exp_lat = (k == 0) ? 1 : (k == 1) ? 2 : 4;
        xfer(k, w, a, d, s, rd, ak, er, lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_ack"}, {31'd0, ak}, {31'd0, ~exp_err});
        check({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        check({tag, "_dat"}, rd, exp_dat);
        @(posedge clk); #1;
        check({tag, "_pulse_end"}, {30'd0, ack[k], err[k]}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        int   j;

        for (int k = 0; k < 3; k++) begin
            cyc[k] = 0; stb[k] = 0; we[k] = 0; adr[k] = 0; wdat[k] = 0; sel[k] = 0;
        end

        vecs[0]  = '{1'b0, 32'h0000_0008, 32'h0,          4'hF, RV,           1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF,  4'hF, RV,           1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0,          4'hF, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0008, 32'h0000_00AA,  4'h1, 32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0,          4'h0, 32'hDEAD_BEAA, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_000B, 32'h1122_3344,  4'hC, 32'hDEAD_BEAA, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_000A, 32'h0,          4'hF, 32'h1122_BEAA, 1'b0};
        vecs[7]  = '{1'b1, 32'h0000_003C, 32'h0102_0304,  4'hF, 32'h1122_BEAA, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_003C, 32'h0,          4'hF, 32'h0102_0304, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0040, 32'h0,          4'hF, ERR_EN ? 32'h0102_0304 : 32'h0, ERR_EN};
        vecs[10] = '{1'b1, 32'h0000_0048, 32'hFFFF_FFFF,  4'hF, ERR_EN ? 32'h0102_0304 : 32'h0, ERR_EN};
        vecs[11] = '{1'b0, 32'h0000_0008, 32'h0,          4'hF, 32'h1122_BEAA, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_1008, 32'h0,          4'hF, ERR_EN ? 32'h1122_BEAA : 32'h0, ERR_EN};
        vecs[13] = '{1'b0, 32'h0000_0000, 32'h0,          4'hF, RV,           1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset_u%0d_outputs", k), {rdat[k][31:2], ack[k], err[k]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Table: single transfers on the one-wait-state instance
        for (int i = 0; i < 14; i++) begin
            run(1, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
                vecs[i].exp_dat, vecs[i].exp_err, $sformatf("v%0d", i));
        end

        // Strobe without cycle must be ignored
        @(negedge clk);
        stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 32'h8; wdat[1] = 32'h0; sel[1] = 4'hF;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen = seen | ack[1] | err[1];
        end
        stb[1] = 1'b0; we[1] = 1'b0;
        check("stb_only_no_term", {31'd0, seen}, 32'd0);
        run(1, 1'b0, 32'h8, 32'h0, 4'hF, 32'h1122_BEAA, 1'b0, "stb_only_readback");

        // Abort during WAIT on the three-wait-state instance
        run(2, 1'b1, 32'h4, 32'hCAFE_0004, 4'hF, 32'h0, 1'b0, "abort_pre_write");
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h4; wdat[2] = 32'h1234; sel[2] = 4'hF;
        @(posedge clk); #1;
        cyc[2] = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen = seen | ack[2] | err[2];
        end
        stb[2] = 1'b0; we[2] = 1'b0;
        check("abort_no_term", {31'd0, seen}, 32'd0);
        run(2, 1'b0, 32'h4, 32'h0, 4'hF, 32'hCAFE_0004, 1'b0, "abort_readback");

        // Back-to-back reads with zero wait states
        for (int i = 0; i < 4; i++) begin
            run(0, 1'b1, 32'(4 * i), 32'h1000_0000 + 32'(i), 4'hF, 32'h0, 1'b0,
                $sformatf("b2b_fill%0d", i));
        end
        @(negedge clk);
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h0; sel[0] = 4'hF;
        @(posedge clk);
        j = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            check($sformatf("b2b_ack_c%0d", c), {31'd0, ack[0]}, {31'd0, (c % 2) == 0});
            if (ack[0]) begin
                check($sformatf("b2b_dat%0d", j), rdat[0], 32'h1000_0000 + 32'(j));
                j++;
                adr[0] = 32'(4 * j);
                if (j == 4) begin
                    cyc[0] = 1'b0; stb[0] = 1'b0;
                end
            end
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;

        // Reset in the middle of a waiting write
        @(negedge clk);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h8; wdat[2] = 32'hFFFF_FFFF; sel[2] = 4'hF;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midwait_reset_u2_dat", rdat[2], 32'h0);
        check("midwait_reset_u2_term", {30'd0, ack[2], err[2]}, 32'd0);
        check("midwait_reset_u1_dat", rdat[1], 32'h0);
        cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            run(1, 1'b0, 32'(4 * i), 32'h0, 4'hF, RV, 1'b0, $sformatf("post_reset_r%0d", i));
        end
        run(2, 1'b0, 32'h8, 32'h0, 4'hF, RV, 1'b0, "post_reset_no_partial");
        run(2, 1'b0, 32'h4, 32'h0, 4'hF, RV, 1'b0, "post_reset_u2_r1");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
